// File: rtl/mmu_stream_ctrl_if.sv
// mmu_stream_ctrl_if: input bank, MMU core and output bank signals seen by the stream controller.
interface mmu_stream_ctrl_if;
    logic [5:0]  in_rd_addr_o;
    logic [31:0] in_rd_data_i;
    logic [7:0]  mmu_input_data_o;
    logic        mmu_valid_input_o;
    logic        mmu_finish_i;
    logic        mmu_read_ram_o;
    logic [17:0] mmu_read_data_i;
    logic        out_wr_en_o;
    logic [7:0]  out_wr_addr_o;
    logic [31:0] out_wr_data_o;
    modport master (
        output in_rd_addr_o, mmu_input_data_o, mmu_valid_input_o, mmu_read_ram_o,
               out_wr_en_o, out_wr_addr_o, out_wr_data_o,
        input  in_rd_data_i, mmu_finish_i, mmu_read_data_i
    );
    modport slave (
        input  in_rd_addr_o, mmu_input_data_o, mmu_valid_input_o, mmu_read_ram_o,
               out_wr_en_o, out_wr_addr_o, out_wr_data_o,
        output in_rd_data_i, mmu_finish_i, mmu_read_data_i
    );
endinterface

// File: rtl/mmu_stream_ctrl.sv
// mmu_stream_ctrl: streams input bank bytes into the MMU core, then copies its results to the output bank.
// Define MMU_STREAM_TIMEOUT_EN to abort a job with err_o after 65535 cycles without mmu_finish_i.
module mmu_stream_ctrl #(
    parameter int NUM_IN_WORDS  = 64,
    parameter int NUM_OUT_WORDS = 160,
    parameter int READ_LAT      = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start_i,
    mmu_stream_ctrl_if.master bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int NUM_BYTES = 4 * NUM_IN_WORDS;
    localparam int IW = $clog2(NUM_BYTES + 1);
    localparam int OW = $clog2(NUM_OUT_WORDS + 1);

    typedef enum logic [2:0] {IDLE, STREAM, WAIT_FIN, READ, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic [IW-1:0] in_cnt;
    logic [OW-1:0] rd_cnt, wr_cnt;
    logic [READ_LAT-1:0] rd_pipe;
    logic start, timeout;

    assign busy_o = state != IDLE && state != DONE;
    assign done_o = state == DONE;
    assign start  = start_i && !busy_o;

    assign bus.mmu_valid_input_o = state == STREAM;
    assign bus.mmu_read_ram_o    = state == READ;
    assign bus.in_rd_addr_o      = bus.mmu_valid_input_o ? 6'(in_cnt >> 2) : '0;
    assign bus.mmu_input_data_o  = bus.mmu_valid_input_o ? 8'(bus.in_rd_data_i >> {in_cnt[1:0], 3'b000}) : '0;

`ifdef MMU_STREAM_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_q;
    // Fires on the 65535th WAIT_FIN cycle, so the counter lands on 65535 as the FSM leaves
    assign timeout = state == WAIT_FIN && !bus.mmu_finish_i && to_cnt == 16'hFFFE;
    assign err_o   = err_q;
    always_ff @(posedge HCLK) begin
        if (!HRESETn || start) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == WAIT_FIN) to_cnt <= to_cnt + 16'd1;
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start_i ? STREAM : state;
            STREAM:     state_nx = in_cnt == IW'(NUM_BYTES - 1) ? WAIT_FIN : STREAM;
            WAIT_FIN:   state_nx = bus.mmu_finish_i ? READ : timeout ? DONE : WAIT_FIN;
            READ:       state_nx = rd_cnt == OW'(NUM_OUT_WORDS - 1) ? DRAIN : READ;
            DRAIN:      state_nx = wr_cnt == OW'(NUM_OUT_WORDS) ? DONE : DRAIN;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nx;
    end

    // rd_pipe tracks which cycles carry valid read data; wr_cnt reaches the terminal count during the last write
    always_ff @(posedge HCLK) begin
        if (!HRESETn || start) begin
            in_cnt            <= '0;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            rd_pipe           <= '0;
            bus.out_wr_en_o   <= 1'b0;
            bus.out_wr_addr_o <= '0;
            bus.out_wr_data_o <= '0;
        end else begin
            if (bus.mmu_valid_input_o) in_cnt <= in_cnt + IW'(1);
            if (bus.mmu_read_ram_o) rd_cnt <= rd_cnt + OW'(1);
            rd_pipe         <= READ_LAT'({rd_pipe, bus.mmu_read_ram_o});
            bus.out_wr_en_o <= rd_pipe[READ_LAT-1];
            if (rd_pipe[READ_LAT-1]) begin
                bus.out_wr_addr_o <= 8'(wr_cnt);
                bus.out_wr_data_o <= {14'b0, bus.mmu_read_data_i};
                wr_cnt            <= wr_cnt + OW'(1);
            end
        end
    end
endmodule

// File: doc/mmu_stream_ctrl.md
MMU_STREAM_CTRL -- requirements
Module: mmu_stream_ctrl

Interface
REQ-001 SHALL have parameter NUM_IN_WORDS, default 64: number of 32-bit input words streamed per job.
REQ-002 SHALL have parameter NUM_OUT_WORDS, default 160: number of 18-bit results read back per job.
REQ-003 SHALL have parameter READ_LAT, default 1: cycles from a mmu_read_ram_o cycle to its mmu_read_data_i being valid.
REQ-004 SHALL use one clock, HCLK; reset HRESETn is synchronous and active-low.
REQ-005 SHALL have port HCLK, input, 1: clock.
REQ-006 SHALL have port HRESETn, input, 1: synchronous active-low reset.
REQ-007 SHALL have port start_i, input, 1: one-cycle job start, from control register bit 0.
REQ-008 SHALL have port in_rd_addr_o, output, 6: input bank word index.
REQ-009 SHALL have port in_rd_data_i, input, 32: input bank word, combinational from in_rd_addr_o.
REQ-010 SHALL have port mmu_input_data_o, output, 8: byte to MMU core.
REQ-011 SHALL have port mmu_valid_input_o, output, 1: byte valid.
REQ-012 SHALL have port mmu_finish_i, input, 1: MMU core compute complete.
REQ-013 SHALL have port mmu_read_ram_o, output, 1: result read request.
REQ-014 SHALL have port mmu_read_data_i, input, 18: result data.
REQ-015 SHALL have port out_wr_en_o, output, 1: output bank write strobe.
REQ-016 SHALL have port out_wr_addr_o, output, 8: output bank word index.
REQ-017 SHALL have port out_wr_data_o, output, 32: result, zero-extended.
REQ-018 SHALL have port busy_o, output, 1: high in any state other than IDLE/DONE.
REQ-019 SHALL have port done_o, output, 1: sticky job complete.
REQ-020 SHALL have port err_o, output, 1: sticky timeout error.

Function
REQ-021 SHALL implement FSM states IDLE, STREAM, WAIT_FIN, READ, DRAIN, DONE.
REQ-022 SHALL move IDLE or DONE to STREAM on the cycle after start_i=1, clearing done_o, err_o and all counters.
REQ-023 SHALL ignore start_i while busy_o=1.
REQ-024 SHALL in STREAM assert mmu_valid_input_o for exactly 4*NUM_IN_WORDS consecutive cycles, with no bubbles.
REQ-025 SHALL drive byte k as in_rd_data_i[8*(k%4)+7 : 8*(k%4)] with in_rd_addr_o=k/4, little-endian with byte 0 first.
REQ-026 SHALL enter WAIT_FIN on the cycle after the last byte; mmu_valid_input_o=0 and mmu_input_data_o=0 outside STREAM.
REQ-027 SHALL ignore mmu_finish_i outside WAIT_FIN; finish asserted during STREAM is not latched.
REQ-028 SHALL move WAIT_FIN to READ on the cycle after mmu_finish_i=1.
REQ-029 SHALL in READ hold mmu_read_ram_o=1 for exactly NUM_OUT_WORDS consecutive cycles, then enter DRAIN.
REQ-030 SHALL capture mmu_read_data_i exactly READ_LAT cycles after each read_ram cycle and write it with out_wr_en_o=1, addresses 0..NUM_OUT_WORDS-1 ascending.
REQ-031 SHALL set out_wr_data_o = {14'b0, mmu_read_data_i}.
REQ-032 SHALL stay in DRAIN until the last write, then enter DONE with done_o=1 held until the next start_i.
REQ-033 SHALL have a job latency from start_i to done_o of 4*NUM_IN_WORDS + (finish wait) + NUM_OUT_WORDS + READ_LAT + 3 cycles.
REQ-034 SHALL compute counter widths as $clog2 of the terminal count plus 1; counters never wrap mid-job.

Reset
REQ-035 SHALL on HRESETn=0 at a HCLK edge enter IDLE and zero all outputs and counters, including mid-job; writes in flight are dropped.
REQ-036 SHALL, after reset release, require a new start_i; no job resumes.

Configuration
REQ-037 SHALL, with MMU_STREAM_TIMEOUT_EN defined, count WAIT_FIN cycles in a 16-bit counter; on reaching 65535 without finish, go to DONE with done_o=1 and err_o=1, and perform no READ.
REQ-038 SHALL, without MMU_STREAM_TIMEOUT_EN, wait in WAIT_FIN indefinitely, with err_o tied to 0 and no counter instantiated.

Verification
REQ-039 SHALL test: input bank word0=32'h04030201, start_i -> bytes 01,02,03,04 on cycles 1-4, with 256 valid cycles total.
REQ-040 SHALL test: finish 10 cycles after WAIT_FIN and model returns data=addr+18'h3F000 with READ_LAT=1 -> 160 writes, word 5 = 32'h0003F005, then done_o=1.
REQ-041 SHALL test: start_i pulsed mid-STREAM -> no restart, and the byte sequence is unchanged.
REQ-042 SHALL test: HRESETn low during READ at write 80 -> next cycle IDLE, all outputs 0, no further writes.
REQ-043 SHALL test: MMU_STREAM_TIMEOUT_EN defined and finish never asserted -> err_o=1, done_o=1 at 65535 cycles in WAIT_FIN, no read_ram.
REQ-044 SHALL test: finish pulsed during STREAM only -> FSM stays in WAIT_FIN until a later finish.
